exe_muldiv_unit: RTL
====================

Name: exe_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit for the EXE stage. Generalises the stage's single-cycle unsigned multiply with a parametrised width and configurable multiply latency, and adds signed/unsigned MULT, MULTU, DIV and DIVU.
- Divide is an iterative radix-2 restoring divider.
- Produces a {hi, lo} result with a one-cycle valid pulse that drives the HILO write enable.
- Asserts busy so the hazard unit can stall the pipeline while an operation is in flight.

Parameters:
- WIDTH, 32, operand width and width of each of hi/lo.
- MUL_CYCLES, 2, multiply latency in clock edges from accept to result; legal values are 1 and above.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous cancel of any in-flight operation.
- start  input  1  request to begin an operation; sampled when ready=1.
- ready  output  1  unit can accept start this cycle.
- op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- src1  input  WIDTH  multiplicand / dividend.
- src2  input  WIDTH  multiplier / divisor.
- busy  output  1  high while an operation is in flight (state MUL or DIV).
- result_valid  output  1  one-cycle pulse; result is on hi_res/lo_res; used as the HILO write enable.
- hi_res  output  WIDTH  product upper half / remainder.
- lo_res  output  WIDTH  product lower half / quotient.

Behaviour:
- Reset is asynchronous on rst_n low. It sets state to IDLE and clears every internal register. Outputs: ready=1, busy=0, result_valid=0, hi_res=0, lo_res=0. Reset mid-operation discards the operation with no result_valid.
- States are IDLE, MUL, DIV and DONE.
- ready=1 in IDLE and DONE. busy=1 in MUL and DIV.
- Accept: on a rising edge where start=1, ready=1 and flush=0, latch op, src1 and src2, clear the iteration counter, then go to MUL (op[1]=0) or DIV (op[1]=1).
- MUL: the counter increments each edge. On the MUL_CYCLES-th edge after accept, register the 2*WIDTH product of the latched operands into {hi_res, lo_res} and go to DONE.
  - Signed product for MULT; zero-extended product for MULTU.
- DIV: operate on operand magnitudes (absolute values for DIV, raw values for DIVU). Perform one restoring shift/subtract iteration per edge.
  - On the WIDTH-th edge after accept, apply sign fix-up and register the result, then go to DONE.
  - Quotient is negated when the operand signs differ (DIV only).
  - Remainder takes the sign of the dividend (DIV only).
  - Divide by zero (src2 latched as 0, either signedness): lo_res = all ones, hi_res = latched src1. Latency is still WIDTH edges.
  - Signed overflow (most-negative / -1): lo_res = 1 followed by WIDTH-1 zeros, hi_res = 0.
- DONE: result_valid=1 for exactly this cycle. Next edge goes to IDLE, or accepts a new operation if start=1 (back-to-back issue).
- hi_res and lo_res hold their value after DONE until the next result is registered.
- Latency: result_valid is high in the cycle after edge N+L, where N is the accept edge. L = MUL_CYCLES for multiply and WIDTH for divide.
- flush=1 at an edge: the next state is IDLE, the counter is cleared, no result is registered and no result_valid is produced. flush overrides start in the same cycle. flush in DONE suppresses nothing, because result_valid has already been asserted that cycle.
- start while busy=1 is ignored; src1, src2 and op may change freely while busy.
- Operand inputs are only sampled at the accept edge.

Test Plan:
- MULT with src1=0xFFFFFFFF, src2=0x00000002 -> result_valid exactly 2 edges after accept (MUL_CYCLES=2); hi_res=0xFFFFFFFF, lo_res=0xFFFFFFFE. The same operands with MULTU -> hi_res=0x00000001, lo_res=0xFFFFFFFE.
- DIV with src1=0xFFFFFFF9 (-7), src2=2 -> result_valid 32 edges after accept; lo_res=0xFFFFFFFD, hi_res=0xFFFFFFFF. The same operands with DIVU -> lo_res=0x7FFFFFFC, hi_res=0x00000001.
- Boundary divides:
  - DIV 0x80000000 / 0xFFFFFFFF -> lo_res=0x80000000, hi_res=0x00000000.
  - DIVU 5 / 0 -> lo_res=0xFFFFFFFF, hi_res=0x00000005, latency 32 edges.
- Back-to-back and stall: start held high with operands changed during busy -> no second accept while busy. A second op is accepted in the DONE cycle and its result_valid follows at the correct latency. busy=1 throughout each operation.
- Flush: DIV accepted, flush asserted on edge 10 -> IDLE next cycle, no result_valid ever, hi_res/lo_res unchanged. flush and start together in IDLE -> nothing accepted.
- Reset: rst_n pulled low asynchronously mid-DIV -> outputs go to their reset values immediately and no result_valid follows. A MULT issued after rst_n release completes normally.

Source files
------------

// File: rtl/exe_muldiv_unit.sv
// exe_muldiv_unit: multi-cycle multiply/divide unit for the EXE stage.
// Supports MULT/MULTU, with a configurable multiply latency, and DIV/DIVU using an
// iterative radix-2 restoring divider that retires one quotient bit per clock.
// Ports:
//   clk, rst_n         clock (rising edge) and asynchronous active-low reset
//   flush              synchronous cancel of any in-flight operation
//   start, ready       issue handshake; start is sampled only while ready=1
//   op                 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src1, src2         multiplicand/dividend and multiplier/divisor
//   busy               operation in flight (used by the hazard unit to stall the pipeline)
//   result_valid       one-cycle pulse that doubles as the HILO write enable
//   hi_res, lo_res     product high/low halves, or remainder/quotient
module exe_muldiv_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             start,
  output logic             ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  localparam int unsigned CntMax = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] MulLast = CntW'(MUL_CYCLES - 1);
  localparam logic [CntW-1:0] DivLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             signed_q, signed_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  // Multiply: sign- or zero-extend the latched operands to 2*WIDTH so the
  // truncated product is correct for both signednesses.
  logic [2*WIDTH-1:0] mul_a, mul_b, product;
  assign mul_a   = {{WIDTH{signed_q & a_q[WIDTH-1]}}, a_q};
  assign mul_b   = {{WIDTH{signed_q & b_q[WIDTH-1]}}, b_q};
  assign product = mul_a * mul_b;

  // Divide: magnitudes only; the signs are fixed up after the final iteration.
  logic [WIDTH-1:0] src1_mag, dvsr_mag;
  assign src1_mag = (~op[0] & src1[WIDTH-1]) ? -src1 : src1;
  assign dvsr_mag = (signed_q & b_q[WIDTH-1]) ? -b_q : b_q;

  logic [WIDTH:0]   shifted, trial;
  logic             fits;
  logic [WIDTH-1:0] rem_step, quo_step, rem_fix, quo_fix;
  logic             div_zero, div_ovf;
  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign trial    = shifted - {1'b0, dvsr_mag};
  assign fits     = ~trial[WIDTH];
  assign rem_step = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_step = {quo_q[WIDTH-2:0], fits};
  assign quo_fix  = (signed_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quo_step : quo_step;
  assign rem_fix  = (signed_q & a_q[WIDTH-1]) ? -rem_step : rem_step;
  assign div_zero = (b_q == '0);
  assign div_ovf  = signed_q && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    signed_d = signed_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          state_d = StIdle;
          if (start) begin
            signed_d = ~op[0];
            a_d      = src1;
            b_d      = src2;
            cnt_d    = '0;
            rem_d    = '0;
            quo_d    = src1_mag;
            state_d  = op[1] ? StDiv : StMul;
          end
        end
        StMul: begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == MulLast) begin
            {hi_d, lo_d} = product;
            state_d      = StDone;
          end
        end
        StDiv: begin
          cnt_d = cnt_q + CntW'(1);
          rem_d = rem_step;
          quo_d = quo_step;
          if (cnt_q == DivLast) begin
            state_d = StDone;
            if (div_zero) begin
              hi_d = a_q;
              lo_d = '1;
            end else if (div_ovf) begin
              hi_d = '0;
              lo_d = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
              hi_d = rem_fix;
              lo_d = quo_fix;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      signed_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      signed_q <= signed_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign ready        = (state_q == StIdle) || (state_q == StDone);
  assign busy         = (state_q == StMul) || (state_q == StDiv);
  assign result_valid = (state_q == StDone);
  assign hi_res       = hi_q;
  assign lo_res       = lo_q;

endmodule
